pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and bubble insertion. It generalises the fixed decode→execute register to any stage boundary (F→D, D→E, E→M, M→W). It adds back-pressure (stall) with full throughput and a registered upstream ready. On flush or drain it presents a zeroed control vector (bubble) so downstream write enables are inactive.

## Interface
- CTRL_W, default 8: control-bit width (e.g. RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, ALUControl[2:0]); zeroed on bubble.
- DATA_W, default 111: payload width (e.g. Rs, Rt, Rd, signImm, RD1, RD2); not semantically checked.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush; discards all held entries.
- valid_i  in  1  upstream entry valid.
- ready_o  out  1  stage can accept; registered.
- ctrl_i  in  CTRL_W  upstream control bits.
- data_i  in  DATA_W  upstream payload.
- valid_o  out  1  downstream entry valid.
- ready_i  in  1  downstream accepts.
- ctrl_o  out  CTRL_W  held control bits; all-zero whenever valid_o=0.
- data_o  out  DATA_W  held payload.
- occ_o  out  2  number of held entries (0..2).

## Operation
- Two slots: main (drives outputs) and skid. Accept = valid_i & ready_o. Emit = valid_o & ready_i.
- ready_o = ~skid_valid, taken from a flop and never from a combinational path on ready_i.
- States: EMPTY (occ 0), ONE (main only), TWO (main + skid).
- EMPTY: accept → ONE, main ← input; otherwise stay.
- ONE: accept & emit → ONE, main ← input. Accept & ~emit → TWO, skid ← input. ~accept & emit → EMPTY. Neither → hold.
- TWO: emit → ONE, main ← skid, skid cleared. ~emit → hold. No accept is possible because ready_o=0.
- On entering EMPTY, ctrl_o ← 0. data_o holds its last value.
- clr=1 (priority below rst, above everything else): next state EMPTY, ctrl_o=0, data_o=0, skid cleared, ready_o=1 next cycle. Any accept or emit in the clr cycle is dropped and not counted. Upstream must not assume the entry was taken.
- Reset mid-operation: all entries lost immediately and asynchronously.
- Outputs never change while valid_o=1 & ready_i=0. This is a stable-hold requirement.
- No arithmetic; widths pass through unchanged.

## Timing
- Reset values: valid_o=0, ctrl_o=0, data_o=0, occ_o=0, ready_o=1. Internal skid=0.
- Latency: input accepted at edge N appears on outputs after edge N (1 cycle).
- Throughput: 1 entry/cycle with ready_i held high; no bubble is inserted by the handshake.
- Stall: when ready_i drops, at most one extra entry is absorbed (skid). ready_o falls one cycle after the skid fills.
- Release: ready_o rises the cycle after the skid drains into main.
- Order is strictly FIFO; no entry is duplicated or lost except on clr or rst.

## Structure
- Shared package pipe_pkg holds:
  - the state encoding constants (EMPTY=2'd0, ONE=2'd1, TWO=2'd2);
  - the default CTRL_W/DATA_W values for each stage boundary (FD, DE, EM, MW).
- Sub-module pipe_slot: one valid+ctrl+data register with load, clear and bubble (ctrl-zero) controls. It is instantiated twice (main, skid).
- The top level contains only the state/occupancy logic and the slot control.

## Test plan
- Reset: drive rst=0 mid-stream with occ=2 → immediately valid_o=0, ctrl_o=0, data_o=0, occ_o=0, ready_o=1.
- Streaming: ready_i=1, push ctrl 8'hA5 / data 0x1..0x4 on consecutive cycles → the same values appear one cycle later, one per cycle, occ_o stays 1.
- Stall/skid: push 0x10, 0x11, 0x12 with ready_i=0 from cycle 1 →
  - 0x10 held on outputs and 0x11 in skid;
  - ready_o=0 from cycle 3;
  - 0x12 is held upstream.
  - On ready_i=1, the outputs are 0x10, 0x11, 0x12 in order, with no gaps.
- Flush: occ=2, assert clr with valid_i=1 →
  - next cycle valid_o=0, ctrl_o=0, data_o=0, occ_o=0, ready_o=1;
  - the input in the clr cycle never appears on the outputs.
- Drain bubble: a single entry ctrl 8'hFF emitted, then valid_i=0 → ctrl_o=0 and valid_o=0 the next cycle; data_o is unchanged.
- Random: random valid_i/ready_i/clr against a scoreboard FIFO model. Check:
  - ordering;
  - outputs stable under stall;
  - ready_o equals occ_o<2 as registered.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: occupancy encoding and
// default control/payload widths for each stage boundary of the 5-stage pipe.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Fetch -> Decode: no control yet; instruction + PC+4.
  localparam int FD_CTRL_W = 1;
  localparam int FD_DATA_W = 64;
  // Decode -> Execute: full control vector; Rs, Rt, Rd, signImm, RD1, RD2.
  localparam int DE_CTRL_W = 8;
  localparam int DE_DATA_W = 111;
  // Execute -> Memory: RegWrite, MemtoReg, MemWrite; ALUOut, WriteData, WriteReg.
  localparam int EM_CTRL_W = 3;
  localparam int EM_DATA_W = 69;
  // Memory -> Writeback: RegWrite, MemtoReg; ReadData, ALUOut, WriteReg.
  localparam int MW_CTRL_W = 2;
  localparam int MW_DATA_W = 69;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding slot: valid + control + payload register with
// clear (zero everything), load, and bubble (drop valid, zero control, keep payload).
module pipe_slot #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              bubble_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end else if (bubble_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer:
// the main slot drives the outputs, the skid slot absorbs one entry under stall.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DE_CTRL_W,
  parameter int DATA_W = DE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o
);

  state_e state_q, state_d;

  logic              main_load, main_sel_skid, main_clear, main_bubble;
  logic              skid_load, skid_clear;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] skid_data, main_data_in;
  logic              accept, emit;

  // ready_o depends only on the skid flop, never on ready_i.
  assign ready_o = ~skid_valid;
  assign accept  = valid_i & ready_o;
  assign emit    = valid_o & ready_i;
  assign occ_o   = state_q;

  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_sel_skid = 1'b0;
    main_clear    = 1'b0;
    main_bubble   = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    if (clr) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = TWO;
          end else if (emit) begin
            main_bubble = 1'b1;
            state_d     = EMPTY;
          end
        end
        TWO: begin
          if (emit) begin
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
            skid_clear    = 1'b1;
            state_d       = ONE;
          end
        end
        default: begin
          state_d    = EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  assign main_ctrl_in = main_sel_skid ? skid_ctrl : ctrl_i;
  assign main_data_in = main_sel_skid ? skid_data : data_i;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (main_clear),
    .load_i   (main_load),
    .bubble_i (main_bubble),
    .ctrl_i   (main_ctrl_in),
    .data_i   (main_data_in),
    .valid_o  (valid_o),
    .ctrl_o   (ctrl_o),
    .data_o   (data_o)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (skid_clear),
    .load_i   (skid_load),
    .bubble_i (1'b0),
    .ctrl_i   (ctrl_i),
    .data_i   (data_i),
    .valid_o  (skid_valid),
    .ctrl_o   (skid_ctrl),
    .data_o   (skid_data)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: accepted entries are queued in FIFO order
// and a negedge monitor checks every presented output against the queue head.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CW = DE_CTRL_W;
  localparam int DW = DE_DATA_W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [CW-1:0] ctrl_i = '0;
  logic [DW-1:0] data_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [CW-1:0] ctrl_o;
  logic [DW-1:0] data_o;
  logic [1:0]    occ_o;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic          have_prev = 1'b0;
  logic [CW-1:0] prev_ctrl;
  logic [DW-1:0] prev_data;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .ctrl_i  (ctrl_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .ctrl_o  (ctrl_o),
    .data_o  (data_o),
    .occ_o   (occ_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then move to just after the next rising edge.
  task automatic cyc(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                     input logic r, input logic cl);
    valid_i = v;
    ctrl_i  = c;
    data_i  = d;
    ready_i = r;
    clr     = cl;
    @(posedge clk);
    #1;
  endtask

  // Record every entry that the upcoming edge will accept.
  always @(negedge clk) begin
    #1;
    if (rst && !clr && valid_i && ready_o) q.push_back('{c: ctrl_i, d: data_i});
  end

  // Monitor: compare presented outputs with the model, then retire on emit.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      have_prev <= 1'b0;
    end else begin
      chk("occ", 128'(occ_o), 128'(q.size()));
      chk("ready_vs_occ", 128'(ready_o), 128'(occ_o < 2'd2));
      chk("valid", 128'(valid_o), 128'(q.size() != 0));
      if (valid_o && q.size() != 0) begin
        chk("ctrl_head", 128'(ctrl_o), 128'(q[0].c));
        chk("data_head", 128'(data_o), 128'(q[0].d));
      end else if (!valid_o) begin
        chk("bubble_ctrl", 128'(ctrl_o), 128'(0));
      end
      if (have_prev) begin
        chk("stall_ctrl", 128'(ctrl_o), 128'(prev_ctrl));
        chk("stall_data", 128'(data_o), 128'(prev_data));
      end
      have_prev <= valid_o && !ready_i && !clr;
      prev_ctrl <= ctrl_o;
      prev_data <= data_o;
      if (clr) q.delete();
      else if (valid_o && ready_i && q.size() != 0) void'(q.pop_front());
    end
  end

  initial begin
    logic [127:0] r128;
    #2;
    chk("rst_valid", 128'(valid_o), 128'(0));
    chk("rst_ctrl",  128'(ctrl_o),  128'(0));
    chk("rst_data",  128'(data_o),  128'(0));
    chk("rst_occ",   128'(occ_o),   128'(0));
    chk("rst_ready", 128'(ready_o), 128'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(0, '0, '0, 1, 0);

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) begin
      cyc(1, CW'(8'hA5), DW'(i), 1, 0);
      chk("stream_data", 128'(data_o), 128'(i));
      chk("stream_occ",  128'(occ_o),  128'(1));
    end
    cyc(0, '0, '0, 1, 0);
    chk("stream_end_valid", 128'(valid_o), 128'(0));

    // Stall with skid absorption, then release without gaps.
    cyc(1, CW'(8'hA5), DW'(16), 0, 0);
    cyc(1, CW'(8'hA5), DW'(17), 0, 0);
    chk("skid_ready", 128'(ready_o), 128'(0));
    cyc(1, CW'(8'hA5), DW'(18), 0, 0);
    cyc(1, CW'(8'hA5), DW'(18), 0, 0);
    chk("skid_hold_data", 128'(data_o), 128'(16));
    chk("skid_hold_occ",  128'(occ_o),  128'(2));
    cyc(1, CW'(8'hA5), DW'(18), 1, 0);
    chk("rel_data1",  128'(data_o),  128'(17));
    chk("rel_ready",  128'(ready_o), 128'(1));
    cyc(1, CW'(8'hA5), DW'(18), 1, 0);
    chk("rel_data2",  128'(data_o),  128'(18));
    chk("rel_valid2", 128'(valid_o), 128'(1));
    cyc(0, '0, '0, 1, 0);

    // Flush with occ=2 and a live input in the clr cycle.
    cyc(1, CW'(8'h3C), DW'(32), 0, 0);
    cyc(1, CW'(8'h3C), DW'(33), 0, 0);
    cyc(1, CW'(8'h3C), DW'(119), 0, 1);
    chk("flush_valid", 128'(valid_o), 128'(0));
    chk("flush_ctrl",  128'(ctrl_o),  128'(0));
    chk("flush_data",  128'(data_o),  128'(0));
    chk("flush_occ",   128'(occ_o),   128'(0));
    chk("flush_ready", 128'(ready_o), 128'(1));
    cyc(0, '0, '0, 1, 0);
    cyc(0, '0, '0, 1, 0);
    chk("flush_nodrop", 128'(valid_o), 128'(0));

    // Drain bubble: control zeroed, payload kept.
    cyc(1, CW'(8'hFF), DW'(85), 1, 0);
    chk("drain_ctrl_live", 128'(ctrl_o), 128'(8'hFF));
    cyc(0, '0, '0, 1, 0);
    chk("drain_valid", 128'(valid_o), 128'(0));
    chk("drain_ctrl",  128'(ctrl_o),  128'(0));
    chk("drain_data",  128'(data_o),  128'(85));

    // Asynchronous reset with two entries held.
    cyc(1, CW'(8'h11), DW'(64), 0, 0);
    cyc(1, CW'(8'h22), DW'(65), 0, 0);
    valid_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_valid", 128'(valid_o), 128'(0));
    chk("arst_ctrl",  128'(ctrl_o),  128'(0));
    chk("arst_data",  128'(data_o),  128'(0));
    chk("arst_occ",   128'(occ_o),   128'(0));
    chk("arst_ready", 128'(ready_o), 128'(1));
    cyc(0, '0, '0, 1, 0);
    rst = 1'b1;
    cyc(0, '0, '0, 1, 0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      r128 = {$urandom, $urandom, $urandom, $urandom};
      cyc($urandom_range(0, 3) != 0, CW'($urandom_range(0, 255)), r128[DW-1:0],
          $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, '0, '0, 1, 0);
    chk("final_empty", 128'(q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
